// File: rtl/if_stage_fetch_if.sv
// rtl/if_stage_fetch_if.sv - fetch stage bundle: control inputs, IM fetch port, IF/ID outputs
interface if_stage_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        br_in_D;
    logic [31:0] instr_F;
    logic [31:0] pc_F;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic [4:0]  excode_D;
    logic        bd_D;

    // Fetch stage side: consumes control and the IM word, produces fetch address and IF/ID
    modport slave (
        input  stall, redirect, redirect_pc, exc_req, eret, epc, br_in_D, instr_F,
        output pc_F, IR_D, PC_D, PC8_D, excode_D, bd_D
    );

    // Core/memory side: drives control and the IM word, observes the fetch stage
    modport master (
        output stall, redirect, redirect_pc, exc_req, eret, epc, br_in_D, instr_F,
        input  pc_F, IR_D, PC_D, PC8_D, excode_D, bd_D
    );
endinterface

// File: rtl/if_stage_fetch.sv
// rtl/if_stage_fetch.sv - MIPS IF stage: PC register, next-PC select, IF/ID register with AdEL tagging
module if_stage_fetch #(
    parameter logic [31:0] PC_RESET     = 32'h0000_3000,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE      = 32'h0000_3000,
    parameter logic [31:0] IM_LAST      = 32'h0000_6FFC
) (
    input  logic              clk,
    input  logic              reset,
    if_stage_fetch_if.slave   fif
);
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc8_q, pc8_d;
    logic [4:0]  exc_q, exc_d;
    logic        bd_q, bd_d;
    logic        addr_err;

    // Fetch address is only legal when word aligned and inside the IM window
    always_comb begin
        addr_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);
    end

    // Next PC: exception entry beats eret, both beat stall; redirect beats sequential
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (fif.exc_req) begin
            pc_d = HANDLER_ADDR;
        end else if (fif.eret) begin
            pc_d = fif.epc;
        end else if (fif.stall) begin
            pc_d = pc_q;
        end else if (fif.redirect) begin
            pc_d = fif.redirect_pc;
        end
    end

    // IF/ID next state: flush on exc/eret, hold on stall, else load the fetched word
    // (delay slot is never squashed; it just carries bd from the branch in D)
    always_comb begin
        ir_d  = ir_q;
        pcd_d = pcd_q;
        pc8_d = pc8_q;
        exc_d = exc_q;
        bd_d  = bd_q;
        if (fif.exc_req || fif.eret) begin
            ir_d  = 32'd0;
            pcd_d = 32'd0;
            pc8_d = 32'd8;
            exc_d = EXC_NONE;
            bd_d  = 1'b0;
        end else if (!fif.stall) begin
            ir_d  = addr_err ? 32'd0 : fif.instr_F;
            pcd_d = pc_q;
            pc8_d = pc_q + 32'd8;
            exc_d = addr_err ? EXC_ADEL : EXC_NONE;
            bd_d  = fif.br_in_D;
        end
    end

    // PC and IF/ID registers; reset takes effect immediately, not at the next edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= PC_RESET;
            ir_q  <= 32'd0;
            pcd_q <= 32'd0;
            pc8_q <= 32'd8;
            exc_q <= EXC_NONE;
            bd_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            pcd_q <= pcd_d;
            pc8_q <= pc8_d;
            exc_q <= exc_d;
            bd_q  <= bd_d;
        end
    end

    // Registered state drives the outputs directly; pc_F feeds the async-read IM
    always_comb begin
        fif.pc_F     = pc_q;
        fif.IR_D     = ir_q;
        fif.PC_D     = pcd_q;
        fif.PC8_D    = pc8_q;
        fif.excode_D = exc_q;
        fif.bd_D     = bd_q;
    end
endmodule

// File: tb/tb_if_stage_fetch.sv
// tb/tb_if_stage_fetch.sv - directed bench for if_stage_fetch
module tb_if_stage_fetch;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_failed;

    if_stage_fetch_if fif ();

    if_stage_fetch dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return 32'hA500_0000 | {16'h0000, a[15:0]};
    endfunction

    assign fif.instr_F = im_word(fif.pc_F);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ir, input logic [31:0] pcd,
                              input logic [4:0] exc, input logic bd);
        check_eq({tag, ".IR_D"}, fif.IR_D, ir);
        check_eq({tag, ".PC_D"}, fif.PC_D, pcd);
        check_eq({tag, ".PC8_D"}, fif.PC8_D, pcd + 32'd8);
        check_eq({tag, ".excode_D"}, {27'd0, fif.excode_D}, {27'd0, exc});
        check_eq({tag, ".bd_D"}, {31'd0, fif.bd_D}, {31'd0, bd});
    endtask

    initial begin
        n_tests = 0;
        n_failed = 0;
        reset = 1'b1;
        fif.stall = 1'b0;
        fif.redirect = 1'b0;
        fif.redirect_pc = 32'd0;
        fif.exc_req = 1'b0;
        fif.eret = 1'b0;
        fif.epc = 32'd0;
        fif.br_in_D = 1'b0;

        #12;
        check_eq("rst.pc_F", fif.pc_F, 32'h3000);
        check_ifid("rst", 32'd0, 32'd0, 5'd0, 1'b0);
        reset = 1'b0;

        // free run
        step();
        check_eq("run1.pc_F", fif.pc_F, 32'h3004);
        check_ifid("run1", im_word(32'h3000), 32'h3000, 5'd0, 1'b0);
        step();
        check_eq("run2.pc_F", fif.pc_F, 32'h3008);
        check_ifid("run2", im_word(32'h3004), 32'h3004, 5'd0, 1'b0);

        // stall two cycles at 0x3008
        fif.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("stall.pc_F", fif.pc_F, 32'h3008);
            check_ifid("stall", im_word(32'h3004), 32'h3004, 5'd0, 1'b0);
        end
        fif.stall = 1'b0;
        step();
        check_eq("resume.pc_F", fif.pc_F, 32'h300C);
        check_ifid("resume", im_word(32'h3008), 32'h3008, 5'd0, 1'b0);
        step();
        check_eq("run3.pc_F", fif.pc_F, 32'h3010);

        // branch in D: delay slot loaded with bd_D, PC redirected on the same edge
        fif.br_in_D = 1'b1;
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h3040;
        step();
        check_eq("br.pc_F", fif.pc_F, 32'h3040);
        check_ifid("br", im_word(32'h3010), 32'h3010, 5'd0, 1'b1);
        fif.br_in_D = 1'b0;
        fif.redirect = 1'b0;
        step();
        check_eq("tgt.pc_F", fif.pc_F, 32'h3044);
        check_ifid("tgt", im_word(32'h3040), 32'h3040, 5'd0, 1'b0);

        // jump to 0x3020
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h3020;
        step();
        check_eq("jmp.pc_F", fif.pc_F, 32'h3020);
        fif.redirect = 1'b0;

        // exception while stalled: handler entry and flush
        fif.exc_req = 1'b1;
        fif.stall = 1'b1;
        step();
        check_eq("exc.pc_F", fif.pc_F, 32'h4180);
        check_ifid("exc", 32'd0, 32'd0, 5'd0, 1'b0);
        fif.exc_req = 1'b0;
        fif.stall = 1'b0;

        // eret to misaligned EPC
        fif.eret = 1'b1;
        fif.epc = 32'h3022;
        step();
        check_eq("eret.pc_F", fif.pc_F, 32'h3022);
        check_ifid("eret", 32'd0, 32'd0, 5'd0, 1'b0);
        fif.eret = 1'b0;
        step();
        check_eq("adel_mis.pc_F", fif.pc_F, 32'h3026);
        check_ifid("adel_mis", 32'd0, 32'h3022, 5'd4, 1'b0);

        // last legal word, then just past the window
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h6FFC;
        step();
        check_eq("last.pc_F", fif.pc_F, 32'h6FFC);
        fif.redirect = 1'b0;
        step();
        check_eq("last_ld.pc_F", fif.pc_F, 32'h7000);
        check_ifid("last_ld", im_word(32'h6FFC), 32'h6FFC, 5'd0, 1'b0);
        step();
        check_ifid("adel_hi", 32'd0, 32'h7000, 5'd4, 1'b0);

        // redirect straight to 0x7000
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h7000;
        step();
        fif.redirect = 1'b0;
        step();
        check_ifid("adel_7000", 32'd0, 32'h7000, 5'd4, 1'b0);

        // PC + 4 wraps at the top of the address space
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'hFFFF_FFFC;
        step();
        fif.redirect = 1'b0;
        step();
        check_eq("wrap.pc_F", fif.pc_F, 32'h0000_0000);
        check_ifid("wrap", 32'd0, 32'hFFFF_FFFC, 5'd4, 1'b0);

        // exc_req and eret together: exception wins
        fif.exc_req = 1'b1;
        fif.eret = 1'b1;
        fif.epc = 32'h3100;
        step();
        check_eq("exc_eret.pc_F", fif.pc_F, 32'h4180);
        check_ifid("exc_eret", 32'd0, 32'd0, 5'd0, 1'b0);
        fif.exc_req = 1'b0;
        fif.eret = 1'b0;
        step();
        check_ifid("handler", im_word(32'h4180), 32'h4180, 5'd0, 1'b0);

        // asynchronous reset mid-cycle during a redirect
        fif.redirect = 1'b1;
        fif.redirect_pc = 32'h3040;
        fif.br_in_D = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst.pc_F", fif.pc_F, 32'h3000);
        check_ifid("arst", 32'd0, 32'd0, 5'd0, 1'b0);
        fif.redirect = 1'b0;
        fif.br_in_D = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
        check_eq("post_rst.pc_F", fif.pc_F, 32'h3004);
        check_ifid("post_rst", im_word(32'h3000), 32'h3000, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
